// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Frame: start, 8 data bits LSB first, even parity, one stop bit.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int   UART_DATA_W = 8;
    localparam int   OVS         = 16;
    localparam int   OVS_MID     = 7;
    localparam logic PARITY_EVEN = 1'b0;

    // Nonzero when data plus received parity bit break the parity rule.
    function automatic logic parity_bad(
        input logic [UART_DATA_W-1:0] d,
        input logic                   p
    );
        return (^d) ^ p ^ PARITY_EVEN;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-clock tick every DIV clocks.
// A synchronous clear realigns the phase to a detected start edge.
module uart_rx_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampling UART receiver with valid/ack output handshake
// and per-frame parity, framing and overrun flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_in,
    input  logic                   rx_ack,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_busy,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun_err
);

    localparam int DIV = CLK_FREQ / (BAUD * OVS);

    if (DIV < 1) begin : g_div_chk
        $error("uart_receiver: CLK_FREQ/(BAUD*OVS) must be >= 1");
    end

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   w_rx_s;
    rx_state_e              r_state;
    rx_state_e              w_next;
    logic [3:0]             r_samp;
    logic [2:0]             r_bit_cnt;
    logic [UART_DATA_W-1:0] r_shift;
    logic                   r_prx;
    logic                   w_tick;
    logic                   w_start;
    logic                   w_mid;
    logic                   w_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s  = r_sync2;
    assign w_start = (r_state == IDLE) && !w_rx_s;
    assign w_mid   = w_tick && (r_samp == 4'(OVS_MID));
    assign w_done  = (r_state == STOP) && w_mid;

    uart_rx_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_samp <= '0;
        end else if (w_start) begin
            r_samp <= '0;
        end else if (w_tick) begin
            r_samp <= r_samp + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (!w_rx_s) w_next = START;
            START:   if (w_mid) w_next = w_rx_s ? IDLE : DATA;
            DATA:    if (w_mid && r_bit_cnt == 3'd7) w_next = PARITY;
            PARITY:  if (w_mid) w_next = STOP;
            // A low stop sample parks in BREAK so a held line cannot retrigger.
            STOP:    if (w_mid) w_next = w_rx_s ? IDLE : BREAK;
            BREAK:   if (w_rx_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_prx     <= 1'b0;
        end else if (w_mid) begin
            if (r_state == START) begin
                r_bit_cnt <= '0;
            end
            if (r_state == DATA) begin
                r_shift   <= {w_rx_s, r_shift[UART_DATA_W-1:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_state == PARITY) begin
                r_prx <= w_rx_s;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (w_done) begin
            rx_data     <= r_shift;
            parity_err  <= parity_bad(r_shift, r_prx);
            frame_err   <= ~w_rx_s;
            overrun_err <= rx_valid & ~rx_ack;
            rx_valid    <= 1'b1;
        end else if (rx_valid && rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames for uart_receiver at 16 clocks per bit,
// compared against a frame-level expectation model.
module tb_uart_receiver;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = 16;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       rx_in  = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;

    int         checks     = 0;
    int         errors     = 0;
    int         cyc        = 0;
    int         last_start = 0;
    int         nsent      = 0;
    int         chg_cyc    = 0;
    logic [7:0] prev_data  = 8'h00;

    uart_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_data !== prev_data) chg_cyc <= cyc;
        prev_data <= rx_data;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx_in = b;
        repeat (BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s);
        @(negedge clk);
        rx_in      = 1'b0;
        last_start = cyc;
        nsent++;
        repeat (BIT_CLKS - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // Expected flags follow from the frame as sent: even parity over
    // data plus parity bit, stop must be 1, overrun if unread byte.
    task automatic check_frame(input string tag, input logic [7:0] d,
                               input logic p, input logic s,
                               input logic ovr);
        logic [7:0] ones;
        ones = 8'd0;
        for (int i = 0; i < 8; i++) ones = ones + 8'(d[i]);
        chk({tag, "_data"}, 32'(rx_data), 32'(d));
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, "_par"}, 32'(parity_err), 32'((ones[0] != p)));
        chk({tag, "_frm"}, 32'(frame_err), 32'(s == 1'b0));
        chk({tag, "_ovr"}, 32'(overrun_err), 32'(ovr));
    endtask

    initial begin
        int         lat;
        int         base;
        logic [7:0] d;
        logic       pflip;
        logic       p;
        logic       s;
        int         gap;
        logic       m_valid;
        logic [7:0] ones;

        repeat (3) @(negedge clk);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_par", 32'(parity_err), 32'd0);
        chk("rst_frm", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun_err), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'hA5, 1'b0, 1'b1);
        check_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
        ack_pulse();
        chk("a5_ackclr", 32'(rx_valid), 32'd0);

        send_frame(8'h3C, 1'b1, 1'b1);
        check_frame("3c", 8'h3C, 1'b1, 1'b1, 1'b0);
        ack_pulse();

        send_frame(8'h81, 1'b0, 1'b0);
        check_frame("81", 8'h81, 1'b0, 1'b0, 1'b0);
        ack_pulse();
        repeat (40) @(negedge clk);
        chk("brk_busy", 32'(rx_busy), 32'd1);
        chk("brk_novalid", 32'(rx_valid), 32'd0);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        chk("brk_idle", 32'(rx_busy), 32'd0);
        chk("brk_nospur", 32'(rx_valid), 32'd0);
        send_frame(8'h55, 1'b0, 1'b1);
        check_frame("55", 8'h55, 1'b0, 1'b1, 1'b0);
        ack_pulse();

        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        lat = chg_cyc - last_start;
        check_frame("ovr22", 8'h22, 1'b0, 1'b1, 1'b1);
        chk("latency", 32'(lat >= 169 && lat <= 173), 32'd1);
        ack_pulse();

        base = nsent;
        fork
            begin
                send_frame(8'h33, 1'b0, 1'b1);
                send_frame(8'h44, 1'b0, 1'b1);
            end
            begin
                for (int k = 0; k < 1000; k++) begin
                    @(negedge clk);
                    if (nsent == base + 2 && cyc == last_start + lat - 1)
                        break;
                end
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        check_frame("ackcmp44", 8'h44, 1'b0, 1'b1, 1'b0);
        ack_pulse();

        m_valid = 1'b0;
        for (int n = 0; n < 16; n++) begin
            d     = 8'($urandom);
            pflip = ($urandom % 4) == 0;
            ones  = 8'd0;
            for (int i = 0; i < 8; i++) ones = ones + 8'(d[i]);
            p     = ones[0] ^ pflip;
            s     = ($urandom % 5) != 0;
            gap   = $urandom_range(3, 12);
            send_frame(d, p, s);
            check_frame($sformatf("rnd%0d", n), d, p, s, m_valid);
            m_valid = 1'b1;
            if ($urandom % 2 == 1) begin
                ack_pulse();
                m_valid = 1'b0;
            end
            rx_in = 1'b1;
            repeat (gap) @(negedge clk);
        end
        if (m_valid) ack_pulse();

        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        chk("glitch_busy", 32'(rx_busy), 32'd1);
        repeat (24) @(negedge clk);
        chk("glitch_idle", 32'(rx_busy), 32'd0);
        chk("glitch_novalid", 32'(rx_valid), 32'd0);

        send_frame(8'h5A, 1'b1, 1'b1);
        check_frame("5a", 8'h5A, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (BIT_CLKS - 1) @(negedge clk);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        chk("mid_busy", 32'(rx_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mrst_data", 32'(rx_data), 32'd0);
        chk("mrst_valid", 32'(rx_valid), 32'd0);
        chk("mrst_busy", 32'(rx_busy), 32'd0);
        chk("mrst_par", 32'(parity_err), 32'd0);
        chk("mrst_frm", 32'(frame_err), 32'd0);
        chk("mrst_ovr", 32'(overrun_err), 32'd0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("mrst_noframe", 32'(rx_valid), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b1);
        check_frame("f0", 8'hF0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive-side counterpart of the UART transmitter. Consumes the serial line the transmitter drives.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Oversamples the line at 16x baud, recovers the byte and presents it on a valid/ack handshake with per-frame error flags.
- Sits between the pad/line and the consuming logic in the UART subsystem.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate in bits/s.
- OVS, 16, oversample factor; fixed at 16 in this release, center sample index = OVS/2-1 = 7.
- DIV, CLK_FREQ/(BAUD*OVS), clocks per oversample tick (derived localparam); elaboration error if < 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line, idle high, asynchronous to clk.
- rx_ack  input  1  consumer accepts rx_data; sampled only while rx_valid=1.
- rx_data  output  8  last received byte.
- rx_valid  output  1  byte available; held until acked.
- rx_busy  output  1  frame in progress (state not IDLE).
- parity_err  output  1  parity mismatch on the byte in rx_data.
- frame_err  output  1  stop bit sampled 0 on the byte in rx_data.
- overrun_err  output  1  a byte completed while rx_valid was still 1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0): all outputs 0. State = IDLE. Counters = 0. Synchronizer flops = 1.
- Reset mid-frame: the frame is discarded and no rx_valid is produced.
- rx_in passes through a 2-flop synchronizer (output rx_s) before any use.
- Tick counter: counts 0..DIV-1 and asserts tick for one clk at DIV-1. It is free-running, but its phase is cleared on start-edge detection.
- Sample counter: 4-bit, 0..15, advances on tick and wraps 15 to 0. All bit samples are taken at sample count 7.
- State IDLE:
  - rx_s=0 goes to START; the sample counter and tick counter are cleared.
  - rx_s=1 stays in IDLE.
- State START: at sample 7, rx_s=0 goes to DATA with bit_cnt=0. rx_s=1 is a glitch: return to IDLE with no flags set.
- State DATA: at each sample 7, shift rx_s into the shift register MSB, moving bits right (LSB-first reception). After bit_cnt=7, go to PARITY.
- State PARITY: at sample 7, capture p_rx and go to STOP.
- State STOP: at sample 7, complete the frame:
  - rx_data <= shift register.
  - parity_err <= (^shift register) ^ p_rx.
  - frame_err <= ~rx_s.
  - overrun_err <= rx_valid & ~rx_ack.
  - rx_valid <= 1.
  - Next state: IDLE if rx_s=1; BREAK if rx_s=0.
- Frame completion happens at the middle of the stop bit, which allows back-to-back frames with one stop bit.
- State BREAK: wait until rx_s=1, then go to IDLE. This stops a held-low line from retriggering frames.
- Latency: rx_valid rises 2 clk (synchronizer) + (10*16+7)*DIV + O(1) clk after the falling edge of the start bit on rx_in.
- Handshake:
  - rx_ack=1 while rx_valid=1 clears rx_valid on the next clk.
  - The error flags hold their values until the next frame completes.
- Completion and rx_ack in the same cycle: the new byte is loaded, rx_valid stays 1, overrun_err=0.
- Completion while rx_valid=1 without ack: the new byte overwrites rx_data and overrun_err=1.
- rx_ack while rx_valid=0 is ignored.
- Parity is even: the transmitted parity bit equals the XOR of the 8 data bits.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - UART_DATA_W=8.
  - OVS=16, OVS_MID=7.
  - PARITY_EVEN constant.
- Sub-module uart_rx_tick_gen: tick counter with a synchronous clear input and a tick output, parameterised by DIV.
- FSM, shift register and flags live in the top.

Test Plan:
1. Bench setup for all scenarios: CLK_FREQ=1_600_000, BAUD=100_000 (DIV=1, 16 clk/bit).
2. Send 0xA5 with parity 0 and stop 1 -> rx_data=0xA5, rx_valid=1, parity_err=0, frame_err=0, overrun_err=0. rx_ack pulse clears rx_valid next clk.
3. Send 0x3C with parity bit forced to 1 -> rx_data=0x3C, parity_err=1, frame_err=0.
4. Send 0x81 with stop bit 0, line held low 40 clk, then high, then 0x55 -> first byte frame_err=1. No spurious frame during the low hold. Second byte 0x55 with clean flags.
5. Send 0x11 then 0x22 back-to-back without ack -> second completion gives rx_data=0x22, overrun_err=1. Repeat with ack in the completion cycle -> overrun_err=0, rx_valid stays 1.
6. Glitch: 4-clk low pulse on an idle line -> returns to IDLE, rx_valid stays 0. Then assert reset=0 mid-DATA of a frame -> all outputs 0 immediately, and the next clean frame 0xF0 is received correctly.
